// File: rtl/proc_defs_pkg.sv
// Shared definitions for the accumulator core tool chain: opcodes, register
// indices, the filler instruction word and the sequencer state encoding.
package proc_defs;
  localparam logic [1:0] OP_IN  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  localparam logic [2:0] REG_A = 3'd0;
  localparam logic [2:0] REG_B = 3'd1;
  localparam logic [2:0] REG_C = 3'd2;
  localparam logic [2:0] REG_D = 3'd3;
  localparam logic [2:0] REG_E = 3'd4;
  localparam logic [2:0] REG_F = 3'd5;
  localparam logic [2:0] REG_G = 3'd6;
  localparam logic [2:0] REG_H = 3'd7;

  // MOV B,B: touches no architectural state and leaves the output bus undriven
  localparam logic [7:0] IDLE_INSTR = 8'h89;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  function automatic logic [1:0] op_of(input logic [7:0] word);
    return word[7:6];
  endfunction
endpackage

// File: rtl/instr_sequencer_if.sv
// Program-load, control, operand-stream and core-facing signals of the sequencer.
interface instr_sequencer_if #(parameter int AW = 4);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          halt;
  logic          op_valid;
  logic [7:0]    op_data;
  logic          op_ready;
  logic [7:0]    instr;
  logic [7:0]    data_out;
  logic          issue;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, start, halt, op_valid, op_data,
    input  op_ready, instr, data_out, issue, pc, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, start, halt, op_valid, op_data,
    output op_ready, instr, data_out, issue, pc, busy, done
  );
endinterface

// File: rtl/instr_sequencer_prog_store.sv
// Program store: register array with one synchronous write port and one
// asynchronous read port; contents survive reset.
module prog_store #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer for the accumulator core: steps a PC through the program
// store, issues one word per cycle and stalls IN words until an operand arrives.
module instr_sequencer
  import proc_defs::*;
#(
  parameter int         DEPTH    = 16,
  parameter int         AW       = 4,
  parameter logic [7:0] FILL_INSTR = IDLE_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_sequencer_if.slave  sif
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  seq_state_e    state, state_n;
  logic [AW-1:0] pc_q, pc_n;
  logic [AW:0]   len_q, len_n;
  logic [7:0]    instr_q, instr_n;
  logic [7:0]    data_q, data_n;
  logic          issue_q, issue_n;
  logic          mem_we;
  logic [7:0]    w;
  logic          w_in, busy, last;

  prog_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
    .clk   (clk),
    .we    (mem_we),
    .waddr (sif.prog_addr),
    .wdata (sif.prog_data),
    .raddr (pc_q),
    .rdata (w)
  );

  assign busy = (state == S_RUN) || (state == S_STALL);
  assign w_in = (op_of(w) == OP_IN);
  assign last = ({1'b0, pc_q} == (len_q - 1'b1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= FILL_INSTR;
      data_q  <= '0;
      issue_q <= 1'b0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      len_q   <= len_n;
      instr_q <= instr_n;
      data_q  <= data_n;
      issue_q <= issue_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    len_n   = len_q;
    instr_n = FILL_INSTR;
    data_n  = data_q;
    issue_n = 1'b0;
    mem_we  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        // A write on the start edge lands before the first fetch reads it
        mem_we = sif.prog_we & rst_n;
        if (sif.halt) begin
          state_n = S_IDLE;
        end else if (sif.start) begin
          len_n   = (sif.prog_len > DEPTH_W) ? DEPTH_W : sif.prog_len;
          pc_n    = '0;
          state_n = (sif.prog_len == '0) ? S_DONE : S_RUN;
        end else if (sif.prog_we) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        if (sif.halt) begin
          state_n = S_IDLE;
          pc_n    = '0;
        end else if (!w_in || sif.op_valid) begin
          instr_n = w;
          issue_n = 1'b1;
          if (w_in) data_n = sif.op_data;
          // pc parks on the last word rather than wrapping
          if (last) begin
            state_n = S_DONE;
          end else begin
            pc_n    = pc_q + 1'b1;
            state_n = S_RUN;
          end
        end else begin
          state_n = S_STALL;
        end
      end
    endcase
  end

  assign sif.op_ready = busy & w_in & ~sif.halt;
  assign sif.instr    = instr_q;
  assign sif.data_out = data_q;
  assign sif.issue    = issue_q;
  assign sif.pc       = pc_q;
  assign sif.busy     = busy;
  assign sif.done     = (state == S_DONE);
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a tiny accumulator-core model
// that executes the issued words.
module tb_instr_sequencer;
  import proc_defs::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   issue_cnt = 0;
  logic [7:0] regs [8];
  logic [7:0] core_out = 8'h00;

  instr_sequencer_if #(.AW(4)) bus ();

  instr_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (bus)
  );

  always #5 clk = ~clk;

  // Core model: consumes instr/data_out exactly as the accumulator core would
  always @(posedge clk) begin
    if (rst_n && bus.issue) begin
      issue_cnt <= issue_cnt + 1;
      case (bus.instr[7:6])
        OP_IN:  regs[bus.instr[5:3]] <= bus.data_out;
        OP_ADD: regs[REG_A] <= regs[REG_A] + regs[bus.instr[2:0]];
        OP_MOV: regs[bus.instr[5:3]] <= regs[bus.instr[2:0]];
        default: core_out <= regs[bus.instr[2:0]];
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
    tick();
    bus.prog_we = 1'b0;
  endtask

  initial begin
    int  base;
    bit  seen_first;
    bit  finished;
    rst_n = 1'b0;
    bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0; bus.prog_len = 0;
    bus.start = 0; bus.halt = 0; bus.op_valid = 0; bus.op_data = 0;
    @(negedge clk);
    tick(); tick();

    // 1 reset state
    chk("rst_instr", bus.instr, 8'h89);
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_pc", bus.pc, 4'd0);
    chk("rst_issue", bus.issue, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_opready", bus.op_ready, 1'b0);
    rst_n = 1'b1;

    wr(4'd0, 8'h00); wr(4'd1, 8'h88); wr(4'd2, 8'h41); wr(4'd3, 8'hC0);
    for (int i = 4; i < 16; i++) wr(4'(i), 8'h40 | 8'(i[2:0]));

    // 2 straight run with operand available
    bus.op_valid = 1; bus.op_data = 8'h05; bus.prog_len = 5'd4; bus.start = 1;
    tick();
    bus.start = 0;
    chk("t2_busy", bus.busy, 1'b1);
    chk("t2_e0_issue", bus.issue, 1'b0);
    chk("t2_opready", bus.op_ready, 1'b1);
    tick();
    chk("t2_w0", bus.instr, 8'h00);
    chk("t2_data", bus.data_out, 8'h05);
    chk("t2_pc1", bus.pc, 4'd1);
    chk("t2_iss0", bus.issue, 1'b1);
    tick();
    chk("t2_w1", bus.instr, 8'h88);
    chk("t2_iss1", bus.issue, 1'b1);
    tick();
    chk("t2_w2", bus.instr, 8'h41);
    tick();
    chk("t2_w3", bus.instr, 8'hC0);
    chk("t2_iss3", bus.issue, 1'b1);
    chk("t2_pc_last", bus.pc, 4'd3);
    tick();
    chk("t2_done", bus.done, 1'b1);
    chk("t2_idle_instr", bus.instr, 8'h89);
    chk("t2_issue_off", bus.issue, 1'b0);
    chk("t2_core_out", core_out, 8'h0A);

    // 3 stall on IN without operand
    bus.op_valid = 0; bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_stall_instr", bus.instr, 8'h89);
      chk("t3_stall_issue", bus.issue, 1'b0);
      chk("t3_stall_ready", bus.op_ready, 1'b1);
      chk("t3_stall_pc", bus.pc, 4'd0);
    end
    bus.op_valid = 1; bus.op_data = 8'h33;
    tick();
    chk("t3_in_instr", bus.instr, 8'h00);
    chk("t3_in_data", bus.data_out, 8'h33);
    chk("t3_in_pc", bus.pc, 4'd1);

    // 4 halt at pc=2
    tick();
    chk("t4_pc2", bus.pc, 4'd2);
    bus.halt = 1;
    tick();
    bus.halt = 0;
    chk("t4_instr", bus.instr, 8'h89);
    chk("t4_busy", bus.busy, 1'b0);
    chk("t4_pc", bus.pc, 4'd0);
    base = issue_cnt;
    tick(); tick();
    chk("t4_no_issue", issue_cnt - base, 0);
    wr(4'd3, 8'hD2);

    // 5 zero length, then length clipped to DEPTH (with write on start edge)
    bus.prog_len = 5'd0; bus.start = 1;
    base = issue_cnt;
    tick();
    bus.start = 0;
    chk("t5_zero_done", bus.done, 1'b1);
    chk("t5_zero_busy", bus.busy, 1'b0);
    tick();
    chk("t5_zero_issues", issue_cnt - base, 0);

    bus.prog_len = 5'd20; bus.start = 1;
    bus.prog_we = 1; bus.prog_addr = 4'd0; bus.prog_data = 8'h90;
    base = issue_cnt;
    tick();
    bus.start = 0; bus.prog_we = 0;
    seen_first = 0; finished = 0;
    for (int i = 0; i < 40 && !finished; i++) begin
      tick();
      if (bus.issue && !seen_first) begin
        seen_first = 1;
        chk("t5_first_word", bus.instr, 8'h90);
      end
      if (bus.done) finished = 1;
    end
    chk("t5_finished", finished, 1'b1);
    tick();
    chk("t5_16_issues", issue_cnt - base, 16);
    chk("t5_pc_parked", bus.pc, 4'd15);

    // 6 prog_we and start ignored while busy
    bus.prog_len = 5'd4; bus.start = 1;
    tick();
    bus.prog_we = 1; bus.prog_addr = 4'd3; bus.prog_data = 8'hFF;
    tick();
    chk("t6_w0", bus.instr, 8'h90);
    chk("t6_pc1", bus.pc, 4'd1);
    tick();
    chk("t6_pc2", bus.pc, 4'd2);
    bus.prog_we = 0; bus.start = 0;
    tick(); tick();
    chk("t6_w3", bus.instr, 8'hD2);
    chk("t6_done", bus.done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
